noc_port_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one router output port between NUM_IN input ports.
- Sits between the input buffers and the output crossbar mux.
- Drives the 3-bit crossbar select register and holds each grant from a packet's head flit through its tail flit.
- Tracks last winner for fairness; signals per-cycle flit transfers to the input buffers.

---
 rtl/noc_port_arbiter.sv | 72 +++++++
 tb/tb_noc_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: round-robin, packet-locked arbiter sharing one router output port between NUM_IN inputs.
// Define ARB_TIMEOUT_EN to force release of a lock whose owner stays idle for TIMEOUT cycles.
module noc_port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic [NUM_IN-1:0] tail_i,
  input  logic              out_ready_i,
  output logic              grant_valid_o,
  output logic [NUM_IN-1:0] grant_o,
  output logic [SEL_W-1:0]  grant_id_o,
  output logic [NUM_IN-1:0] xfer_o,
  output logic              timeout_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] rr_ptr, rr_n, gid_n, pick, g_next;
  logic [SEL_W:0] idx;
  logic [NUM_IN-1:0] onehot;
  logic locked, found, xfer_g, tail_xfer, release_lock;
  assign locked    = state == LOCKED;
  assign onehot    = NUM_IN'(1) << grant_id_o;
  assign xfer_g    = locked & req_i[grant_id_o] & out_ready_i;
  assign tail_xfer = xfer_g & tail_i[grant_id_o];
  assign g_next    = (grant_id_o == SEL_W'(NUM_IN - 1)) ? '0 : grant_id_o + 1'b1;
  // first requester at or after rr_ptr, wrapping modulo NUM_IN
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      idx = (idx >= (SEL_W+1)'(NUM_IN)) ? idx - (SEL_W+1)'(NUM_IN) : idx;
      if (!found && req_i[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[SEL_W-1:0];
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  assign timeout_o = locked & ~req_i[grant_id_o] & (idle_cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk)
    if (rst || !locked || req_i[grant_id_o] || timeout_o) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 8'd1;
`else
  assign timeout_o = 1'b0;
`endif
  assign release_lock = tail_xfer | timeout_o;
  always_comb begin
    state_n = locked ? (release_lock ? IDLE : LOCKED) : (found ? LOCKED : IDLE);
    gid_n   = (!locked && found) ? pick : grant_id_o;
    rr_n    = (locked && release_lock) ? g_next : rr_ptr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      grant_id_o <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_n;
      grant_id_o <= gid_n;
      rr_ptr     <= rr_n;
    end
  assign grant_valid_o = locked;
  assign grant_o       = locked ? onehot : '0;
  assign xfer_o        = xfer_g ? onehot : '0;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: vector table plus hand-written sequences, checked through an expected-output queue.
module tb_noc_port_arbiter;
  localparam int N  = 5;
  localparam int SW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, tail = '0;
  logic rdy = 1'b0;
  logic gv, to;
  logic [N-1:0] grant, xfer;
  logic [SW-1:0] gid;
  noc_port_arbiter #(.NUM_IN(N), .SEL_W(SW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .out_ready_i(rdy),
    .grant_valid_o(gv), .grant_o(grant), .grant_id_o(gid), .xfer_o(xfer), .timeout_o(to)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic          gv;
    logic [N-1:0]  grant;
    logic [SW-1:0] gid;
    logic [N-1:0]  xfer;
    logic          to;
  } out_t;
  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         rdy;
    out_t         exp;
  } vec_t;
  out_t sb[$];
  string tag[$];
  vec_t tbl[$];
  int applied = 0, miscompares = 0;
  out_t e, a;
  string nm;
  function automatic out_t o(logic g, int id, logic [N-1:0] x, logic t = 1'b0);
    out_t r;
    r.gv    = g;
    r.gid   = SW'(id);
    r.grant = g ? (N'(1) << id) : '0;
    r.xfer  = x;
    r.to    = t;
    return r;
  endfunction
  function automatic vec_t v(logic r, logic [N-1:0] q, logic [N-1:0] t, logic y, out_t x);
    vec_t z;
    z.r = r; z.req = q; z.tail = t; z.rdy = y; z.exp = x;
    return z;
  endfunction
  task automatic apply(vec_t x, string name);
    @(posedge clk);
    #1;
    rst  = x.r;
    req  = x.req;
    tail = x.tail;
    rdy  = x.rdy;
    sb.push_back(x.exp);
    tag.push_back(name);
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      nm = tag.pop_front();
      a  = '{gv, grant, gid, xfer, to};
      applied++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got gv=%b grant=%b id=%0d xfer=%b to=%b, expected gv=%b grant=%b id=%0d xfer=%b to=%b",
                 nm, a.gv, a.grant, a.gid, a.xfer, a.to, e.gv, e.grant, e.gid, e.xfer, e.to);
      end
    end
  initial begin
    int ids[6] = '{3, 4, 0, 1, 2, 3};
    int prev;
    // reset state
    tbl.push_back(v(1, 5'b00000, 5'b00000, 1, o(0, 0, 0)));
    tbl.push_back(v(1, 5'b11111, 5'b11111, 1, o(0, 0, 0)));
    // single-flit packet on input 2
    tbl.push_back(v(0, 5'b00100, 5'b00100, 1, o(0, 0, 0)));
    tbl.push_back(v(0, 5'b00100, 5'b00100, 1, o(1, 2, 5'b00100)));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, o(0, 2, 0)));
    // all requesting, single-flit packets: 3,4,0,1,2,3 with IDLE gaps
    prev = 2;
    foreach (ids[i]) begin
      tbl.push_back(v(0, 5'b11111, 5'b11111, 1, o(0, prev, 0)));
      tbl.push_back(v(0, 5'b11111, 5'b11111, 1, o(1, ids[i], N'(1) << ids[i])));
      prev = ids[i];
    end
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, o(0, 3, 0)));
    // wrap-around: rr_ptr=4 with inputs 4 and 0 requesting
    tbl.push_back(v(0, 5'b10001, 5'b10001, 1, o(0, 3, 0)));
    tbl.push_back(v(0, 5'b10001, 5'b10001, 1, o(1, 4, 5'b10000)));
    tbl.push_back(v(0, 5'b00001, 5'b00001, 1, o(0, 4, 0)));
    tbl.push_back(v(0, 5'b00001, 5'b00001, 1, o(1, 0, 5'b00001)));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, o(0, 0, 0)));
    // 4-flit packet on input 1 with 2 stall cycles; input 0 waits
    tbl.push_back(v(0, 5'b00011, 5'b00001, 1, o(0, 0, 0)));
    tbl.push_back(v(0, 5'b00011, 5'b00001, 1, o(1, 1, 5'b00010)));
    tbl.push_back(v(0, 5'b00011, 5'b00001, 0, o(1, 1, 0)));
    tbl.push_back(v(0, 5'b00011, 5'b00001, 0, o(1, 1, 0)));
    tbl.push_back(v(0, 5'b00011, 5'b00001, 1, o(1, 1, 5'b00010)));
    tbl.push_back(v(0, 5'b00011, 5'b00001, 1, o(1, 1, 5'b00010)));
    tbl.push_back(v(0, 5'b00011, 5'b00011, 1, o(1, 1, 5'b00010)));
    tbl.push_back(v(0, 5'b00001, 5'b00001, 1, o(0, 1, 0)));
    tbl.push_back(v(0, 5'b00001, 5'b00001, 1, o(1, 0, 5'b00001)));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, o(0, 0, 0)));
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
    // reset mid-packet on input 3 drops the lock and clears rr_ptr (else input 1 would win)
    apply(v(0, 5'b01000, 5'b00000, 1, o(0, 0, 0)), "rst_mid_idle");
    apply(v(0, 5'b01000, 5'b00000, 1, o(1, 3, 5'b01000)), "rst_mid_head");
    apply(v(1, 5'b00000, 5'b00000, 1, o(1, 3, 0)), "rst_mid_assert");
    apply(v(0, 5'b11111, 5'b11111, 1, o(0, 0, 0)), "rst_mid_after");
    apply(v(0, 5'b11111, 5'b11111, 1, o(1, 0, 5'b00001)), "rst_mid_rr0");
    apply(v(0, 5'b00000, 5'b00000, 1, o(0, 0, 0)), "rst_mid_end");
    // input 2 goes quiet after its head flit while input 0 keeps requesting
    apply(v(0, 5'b00100, 5'b00000, 1, o(0, 0, 0)), "idle_lock_arb");
    apply(v(0, 5'b00100, 5'b00000, 1, o(1, 2, 5'b00100)), "idle_lock_head");
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++)
      apply(v(0, 5'b00001, 5'b00000, 1, o(1, 2, 0, i == 15)), $sformatf("timeout_bubble%0d", i));
`else
    for (int i = 1; i <= 20; i++)
      apply(v(0, 5'b00001, 5'b00000, 1, o(1, 2, 0)), $sformatf("held_bubble%0d", i));
    apply(v(0, 5'b00101, 5'b00101, 1, o(1, 2, 5'b00100)), "held_tail");
`endif
    apply(v(0, 5'b11111, 5'b11111, 1, o(0, 2, 0)), "post_release_idle");
    apply(v(0, 5'b11111, 5'b11111, 1, o(1, 3, 5'b01000)), "post_release_rr3");
    apply(v(0, 5'b00000, 5'b00000, 1, o(0, 3, 0)), "final_idle");
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
